ddr2_port_arbiter: RTL and testbench

Shares the single DDR2 user command port (req/ack/addr/read/fin, 256-bit write data, 128-bit two-beat read return) between two sequential clients: client 0 (reader) and client 1 (writer or second reader).
- Arbitration is round-robin with burst-length preemption.
- Read-return beats are routed back to the issuing client through an in-order tag FIFO.
- Sits between the sequential reader/writer blocks and the DDR2 controller; everything runs in the ddr2_clk domain.

---
 rtl/ddr2_pkg.sv | 22 ++
 rtl/ddr2_tag_fifo.sv | 51 +++++
 rtl/ddr2_port_arbiter.sv | 149 ++++++++++++++
 tb/tb_ddr2_port_arbiter.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr2_pkg.sv
// Shared types and widths for the DDR2 user-port arbiter slice.
package ddr2_pkg;

    localparam int ADDR_W         = 31;
    localparam int WDATA_W        = 256;
    localparam int MASK_W         = 32;
    localparam int RDATA_W        = 128;
    localparam int BEATS_PER_READ = 2;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } ddr2_state_e;

    // Round-robin pick: a lone requester wins; on a tie the client that
    // did not hold the last grant wins.
    function automatic logic pick_winner(input logic c0_req, input logic c1_req,
                                         input logic last_owner);
        return c1_req & (~c0_req | ~last_owner);
    endfunction

endpackage

// File: rtl/ddr2_tag_fifo.sv
// In-order FIFO of 1-bit client tags for read commands still awaiting data.
module ddr2_tag_fifo #(
    parameter int TAG_DEPTH = 32,
    parameter int TAG_AW    = 5
) (
    input  logic            ddr2_clk,
    input  logic            RST,
    input  logic            push,
    input  logic            tag_in,
    input  logic            pop,
    output logic            head,
    output logic            full,
    output logic            empty,
    output logic [TAG_AW:0] count
);

    logic              mem [TAG_DEPTH];
    logic [TAG_AW-1:0] wr_ptr;
    logic [TAG_AW-1:0] rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == (TAG_AW+1)'(TAG_DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Tag storage; contents need no reset because count guards every read.
    always_ff @(posedge ddr2_clk) begin
        if (do_push) mem[wr_ptr] <= tag_in;
    end

    // Pointers wrap naturally at TAG_DEPTH; count tracks occupancy.
    always_ff @(posedge ddr2_clk or posedge RST) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ddr2_port_arbiter.sv
// Two-client round-robin arbiter for the DDR2 user command port, with
// in-order routing of two-beat read returns back to the issuing client.
//
// Handshake: a command transfers on every cycle where m_req and m_ack are
// both high; the owning client sees that same cycle as cN_ack and must then
// present its next command (or drop req). m_valid carries one read beat per
// cycle with no back-pressure; every read ack returns exactly two beats.
module ddr2_port_arbiter
    import ddr2_pkg::*;
#(
    parameter int TAG_DEPTH = 32,
    parameter int TAG_AW    = 5,
    parameter int MAX_BURST = 64,
    parameter int BURST_W   = 7
) (
    input  logic               ddr2_clk,
    input  logic               RST,
    input  logic               c0_req,
    input  logic               c1_req,
    output logic               c0_ack,
    output logic               c1_ack,
    input  logic [ADDR_W-1:0]  c0_addr,
    input  logic [ADDR_W-1:0]  c1_addr,
    input  logic               c0_read,
    input  logic               c1_read,
    input  logic               c0_fin,
    input  logic               c1_fin,
    input  logic [WDATA_W-1:0] c0_data_write,
    input  logic [WDATA_W-1:0] c1_data_write,
    input  logic [MASK_W-1:0]  c0_mask,
    input  logic [MASK_W-1:0]  c1_mask,
    output logic               c0_valid,
    output logic               c1_valid,
    output logic [RDATA_W-1:0] c_data_read,
    output logic               m_req,
    input  logic               m_ack,
    output logic [ADDR_W-1:0]  m_addr,
    output logic               m_read,
    output logic               m_fin,
    output logic [WDATA_W-1:0] m_data_write,
    output logic [MASK_W-1:0]  m_mask,
    input  logic               m_valid,
    input  logic [RDATA_W-1:0] m_data_read,
    output logic               owner,
    output logic               busy,
    output logic               err_orphan
);

    localparam logic LAST_BEAT = 1'(BEATS_PER_READ - 1);

    ddr2_state_e       state;
    logic              last_owner;
    logic [BURST_W-1:0] burst_cnt;
    logic              beat_tog;
    logic              granted;
    logic              own_req;
    logic              own_read;
    logic              own_fin;
    logic              ack_in;
    logic              tag_push;
    logic              tag_pop;
    logic              tag_head;
    logic              tag_full;
    logic              tag_empty;
    logic [TAG_AW:0]   tag_count;

    assign granted     = (state == S_GRANT);
    assign busy        = granted;
    assign ack_in      = granted & m_ack;
    assign tag_push    = ack_in & own_read;
    assign tag_pop     = m_valid & (beat_tog == LAST_BEAT);
    assign c_data_read = m_data_read;

    // Owner-side mux and command-port gating; everything idles at zero.
    always_comb begin
        own_req      = owner ? c1_req  : c0_req;
        own_read     = owner ? c1_read : c0_read;
        own_fin      = owner ? c1_fin  : c0_fin;
        m_req        = granted & own_req & ~(own_read & tag_full);
        m_fin        = m_req & (own_fin | (burst_cnt == BURST_W'(MAX_BURST - 1)));
        m_read       = granted & own_read;
        m_addr       = '0;
        m_data_write = '0;
        m_mask       = '0;
        if (granted) begin
            m_addr       = owner ? c1_addr       : c0_addr;
            m_data_write = owner ? c1_data_write : c0_data_write;
            m_mask       = owner ? c1_mask       : c0_mask;
        end
        c0_ack   = ack_in & ~owner;
        c1_ack   = ack_in & owner;
        c0_valid = m_valid & ~tag_empty & ~tag_head;
        c1_valid = m_valid & ~tag_empty & tag_head;
    end

    // Arbitration FSM: one idle cycle to pick a winner, then hold the grant
    // until a final ack (client fin or burst limit) or the client withdraws.
    always_ff @(posedge ddr2_clk or posedge RST) begin
        if (RST) begin
            state      <= S_IDLE;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            burst_cnt  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (c0_req | c1_req) begin
                        owner      <= pick_winner(c0_req, c1_req, last_owner);
                        last_owner <= pick_winner(c0_req, c1_req, last_owner);
                        burst_cnt  <= '0;
                        state      <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (ack_in) burst_cnt <= burst_cnt + 1'b1;
                    if ((ack_in & m_fin) | ~own_req) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Beat parity and the sticky flag for data arriving with no tag queued.
    always_ff @(posedge ddr2_clk or posedge RST) begin
        if (RST) begin
            beat_tog   <= 1'b0;
            err_orphan <= 1'b0;
        end else if (m_valid) begin
            beat_tog <= ~beat_tog;
            if (tag_count == '0) err_orphan <= 1'b1;
        end
    end

    ddr2_tag_fifo #(
        .TAG_DEPTH (TAG_DEPTH),
        .TAG_AW    (TAG_AW)
    ) u_tag_fifo (
        .ddr2_clk (ddr2_clk),
        .RST      (RST),
        .push     (tag_push),
        .tag_in   (owner),
        .pop      (tag_pop),
        .head     (tag_head),
        .full     (tag_full),
        .empty    (tag_empty),
        .count    (tag_count)
    );

endmodule

// File: tb/tb_ddr2_port_arbiter.sv
// Bench for ddr2_port_arbiter: directed scenarios plus a randomized phase,
// checked against a transaction-level model (tag queue, ack log, beat log).
module tb_ddr2_port_arbiter;

    localparam int TD = 4;
    localparam int MB = 4;

    logic         ddr2_clk = 1'b0;
    logic         RST;
    logic         c0_req, c1_req, c0_ack, c1_ack;
    logic [30:0]  c0_addr, c1_addr;
    logic         c0_read, c1_read, c0_fin, c1_fin;
    logic [255:0] c0_data_write, c1_data_write;
    logic [31:0]  c0_mask, c1_mask;
    logic         c0_valid, c1_valid;
    logic [127:0] c_data_read;
    logic         m_req, m_ack, m_read, m_fin;
    logic [30:0]  m_addr;
    logic [255:0] m_data_write;
    logic [31:0]  m_mask;
    logic         m_valid;
    logic [127:0] m_data_read;
    logic         owner, busy, err_orphan;

    logic         ack_en;
    assign m_ack = m_req & ack_en;

    ddr2_port_arbiter #(.TAG_DEPTH(TD), .TAG_AW(2), .MAX_BURST(MB), .BURST_W(3)) dut (
        .ddr2_clk(ddr2_clk), .RST(RST),
        .c0_req(c0_req), .c1_req(c1_req), .c0_ack(c0_ack), .c1_ack(c1_ack),
        .c0_addr(c0_addr), .c1_addr(c1_addr), .c0_read(c0_read), .c1_read(c1_read),
        .c0_fin(c0_fin), .c1_fin(c1_fin),
        .c0_data_write(c0_data_write), .c1_data_write(c1_data_write),
        .c0_mask(c0_mask), .c1_mask(c1_mask),
        .c0_valid(c0_valid), .c1_valid(c1_valid), .c_data_read(c_data_read),
        .m_req(m_req), .m_ack(m_ack), .m_addr(m_addr), .m_read(m_read), .m_fin(m_fin),
        .m_data_write(m_data_write), .m_mask(m_mask),
        .m_valid(m_valid), .m_data_read(m_data_read),
        .owner(owner), .busy(busy), .err_orphan(err_orphan)
    );

    // Clock
    always #5 ddr2_clk = ~ddr2_clk;

    // Client model state
    int           cmd_left [2];
    logic         rd       [2];
    logic [30:0]  addr_v   [2];
    logic [255:0] wd_v     [2];
    logic [31:0]  mk_v     [2];
    bit           ack_seen [2];

    // Reference model / scoreboard state
    logic [0:0]   exp_q[$];
    bit           parity;
    bit           exp_orphan;
    int           ret_pending;
    int           ret_allow;
    int           ack_pct, ret_pct;
    bit           force_orphan;
    int           acks_in_grant;
    int           vcnt [2];
    int           ack_owner_log[$];
    bit           ack_fin_log[$];
    int           valid_log[$];
    int           coincide;
    int           full_wr_acks;
    int           reads_issued;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic new_payload(input int k);
        addr_v[k] = 31'($urandom());
        wd_v[k]   = {$urandom(), $urandom(), $urandom(), $urandom(),
                     $urandom(), $urandom(), $urandom(), $urandom()};
        mk_v[k]   = $urandom();
    endtask

    task automatic clear_logs();
        vcnt[0] = 0; vcnt[1] = 0;
        ack_owner_log.delete(); ack_fin_log.delete(); valid_log.delete();
        coincide = 0; full_wr_acks = 0; reads_issued = 0;
    endtask

    // Driver: advance clients on acks seen last cycle, then drive controller side
    task automatic drive();
        for (int k = 0; k < 2; k++) begin
            if (ack_seen[k]) begin
                if (cmd_left[k] > 0) cmd_left[k]--;
                new_payload(k);
            end
        end
        c0_req = (cmd_left[0] != 0); c0_fin = (cmd_left[0] == 1); c0_read = rd[0];
        c1_req = (cmd_left[1] != 0); c1_fin = (cmd_left[1] == 1); c1_read = rd[1];
        c0_addr = addr_v[0]; c0_data_write = wd_v[0]; c0_mask = mk_v[0];
        c1_addr = addr_v[1]; c1_data_write = wd_v[1]; c1_mask = mk_v[1];
        if (force_orphan) begin
            m_valid = 1'b1;
            force_orphan = 1'b0;
        end else if (ret_pending > 0 && ret_allow != 0 && $urandom_range(0, 99) < ret_pct) begin
            m_valid = 1'b1;
            if (ret_allow > 0) ret_allow--;
        end else begin
            m_valid = 1'b0;
        end
        m_data_read = {$urandom(), $urandom(), $urandom(), $urandom()};
        ack_en = ($urandom_range(0, 99) < ack_pct);
    endtask

    // Monitor + scoreboard, sampled at the falling edge
    task automatic monitor();
        int  k;
        bit  popped;
        bit  efin;
        ack_seen[0] = 0; ack_seen[1] = 0;
        popped = 0;
        chk("err_orphan", err_orphan, exp_orphan);
        if (!busy) chk("idle_mreq", m_req, 1'b0);
        if (busy && exp_q.size() == TD) chk("full_gate", m_req & m_read, 1'b0);
        if (m_valid) begin
            if (exp_q.size() == 0) begin
                chk("orphan_c0v", c0_valid, 1'b0);
                chk("orphan_c1v", c1_valid, 1'b0);
                exp_orphan = 1'b1;
            end else begin
                k = int'(exp_q[0]);
                chk("route_c0v", c0_valid, k == 0);
                chk("route_c1v", c1_valid, k == 1);
                chk("rdata", c_data_read, m_data_read);
                vcnt[k]++;
                valid_log.push_back(k);
                if (parity) begin
                    void'(exp_q.pop_front());
                    popped = 1;
                end
            end
            if (ret_pending > 0) ret_pending--;
            parity = ~parity;
        end else begin
            chk("noval_c0v", c0_valid, 1'b0);
            chk("noval_c1v", c1_valid, 1'b0);
        end
        if (m_ack) begin
            k = c1_ack ? 1 : 0;
            efin = (cmd_left[k] == 1) || (acks_in_grant == MB - 1);
            chk("ack_onehot", c0_ack ^ c1_ack, 1'b1);
            chk("ack_owner", owner, k);
            chk("mux_addr", m_addr, addr_v[k]);
            chk("mux_read", m_read, rd[k]);
            chk("mux_wdata", m_data_write, wd_v[k]);
            chk("mux_mask", m_mask, mk_v[k]);
            chk("m_fin", m_fin, efin);
            if (!rd[k] && exp_q.size() == TD) full_wr_acks++;
            if (rd[k]) begin
                if (popped) coincide++;
                exp_q.push_back(1'(k));
                ret_pending += 2;
                reads_issued++;
            end
            ack_owner_log.push_back(k);
            ack_fin_log.push_back(efin);
            acks_in_grant = efin ? 0 : acks_in_grant + 1;
            ack_seen[k] = 1;
        end else begin
            chk("noack_c0", c0_ack, 1'b0);
            chk("noack_c1", c1_ack, 1'b0);
        end
    endtask

    task automatic tick();
        @(posedge ddr2_clk);
        #1;
        drive();
        @(negedge ddr2_clk);
        monitor();
    endtask

    task automatic wait_cmds(input string tag, input int bound);
        int n = 0;
        while (!(cmd_left[0] == 0 && cmd_left[1] == 0 && !busy) && n < bound) begin
            tick();
            n++;
        end
        chk(tag, n < bound, 1'b1);
    endtask

    task automatic wait_drain(input string tag, input int bound);
        int n = 0;
        while (ret_pending != 0 && n < bound) begin
            tick();
            n++;
        end
        chk(tag, n < bound, 1'b1);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        c0_req = 0; c1_req = 0; c0_read = 0; c1_read = 0; c0_fin = 0; c1_fin = 0;
        c0_addr = '0; c1_addr = '0; c0_data_write = '0; c1_data_write = '0;
        c0_mask = '0; c1_mask = '0; m_valid = 0; m_data_read = '0; ack_en = 0;
        cmd_left[0] = 0; cmd_left[1] = 0; rd[0] = 0; rd[1] = 0;
        ack_seen[0] = 0; ack_seen[1] = 0;
        exp_q.delete(); parity = 0; exp_orphan = 0; ret_pending = 0;
        ret_allow = -1; force_orphan = 0; acks_in_grant = 0;
        ack_pct = 100; ret_pct = 100;
        new_payload(0); new_payload(1);
        clear_logs();
        repeat (2) @(posedge ddr2_clk);
        @(negedge ddr2_clk);
        chk("rst_m_req", m_req, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_owner", owner, 1'b0);
        chk("rst_err_orphan", err_orphan, 1'b0);
        chk("rst_acks", {c0_ack, c1_ack}, 2'b00);
        chk("rst_valids", {c0_valid, c1_valid}, 2'b00);
        chk("rst_m_addr", m_addr, '0);
        chk("rst_m_rdfin", {m_read, m_fin}, 2'b00);
        chk("rst_m_wdata", m_data_write, '0);
        chk("rst_m_mask", m_mask, '0);
        chk("rst_rdata", c_data_read, '0);
        RST = 1'b0;
    endtask

    initial begin
        do_reset();

        // 1: single reader, three commands with fin on the third
        cmd_left[0] = 3; rd[0] = 1;
        tick();
        chk("t1_latency_mreq", m_req, 1'b0);
        chk("t1_latency_busy", busy, 1'b0);
        tick();
        chk("t1_mreq_up", m_req, 1'b1);
        wait_cmds("t1_cmd_timeout", 50);
        wait_drain("t1_drain_timeout", 50);
        chk("t1_nacks", ack_owner_log.size(), 3);
        for (int i = 0; i < ack_owner_log.size(); i++) begin
            chk("t1_ack_owner", ack_owner_log[i], 0);
            chk("t1_ack_fin", ack_fin_log[i], i == 2);
        end
        chk("t1_c0_beats", vcnt[0], 6);
        chk("t1_c1_beats", vcnt[1], 0);
        chk("t1_idle", busy, 1'b0);

        // 2: both clients stream; bursts preempted at MB acks, alternating
        do_reset();
        cmd_left[0] = 12; rd[0] = 1;
        cmd_left[1] = 12; rd[1] = 0;
        wait_cmds("t2_cmd_timeout", 400);
        wait_drain("t2_drain_timeout", 100);
        chk("t2_nacks", ack_owner_log.size(), 24);
        for (int i = 0; i < ack_owner_log.size(); i++) begin
            chk("t2_ack_owner", ack_owner_log[i], (i / MB) % 2);
            chk("t2_ack_fin", ack_fin_log[i], (i % MB) == MB - 1);
        end
        chk("t2_c0_beats", vcnt[0], 24);
        chk("t2_c1_beats", vcnt[1], 0);

        // 3: returns withheld; c0 two reads then c1 one read, then release
        clear_logs();
        ret_allow = 0;
        cmd_left[0] = 2; rd[0] = 1;
        wait_cmds("t3_c0_timeout", 50);
        cmd_left[1] = 1; rd[1] = 1;
        wait_cmds("t3_c1_timeout", 50);
        ret_allow = -1;
        wait_drain("t3_drain_timeout", 50);
        chk("t3_nbeats", valid_log.size(), 6);
        for (int i = 0; i < valid_log.size(); i++)
            chk("t3_beat_dest", valid_log[i], (i < 4) ? 0 : 1);

        // 4: tag FIFO full stalls reads but not writes
        clear_logs();
        ret_allow = 0;
        cmd_left[0] = -1; rd[0] = 1;
        begin
            int n = 0;
            while (exp_q.size() < TD && n < 50) begin tick(); n++; end
            chk("t4_fill_timeout", n < 50, 1'b1);
        end
        repeat (3) tick();
        chk("t4_full_mreq", m_req, 1'b0);
        chk("t4_full_busy", busy, 1'b1);
        cmd_left[0] = 0; acks_in_grant = 0;
        cmd_left[1] = 1; rd[1] = 0;
        wait_cmds("t4_wr_timeout", 50);
        chk("t4_write_acked_full", full_wr_acks, 1);
        cmd_left[0] = 1; rd[0] = 1;
        begin
            int n = 0;
            while (!busy && n < 20) begin tick(); n++; end
            chk("t4_regrant_timeout", n < 20, 1'b1);
        end
        tick();
        chk("t4_still_gated", m_req, 1'b0);
        begin
            int n = 0;
            int v0 = vcnt[0];
            ret_allow = 2;
            while (vcnt[0] < v0 + 2 && n < 20) begin tick(); n++; end
            chk("t4_pair_timeout", n < 20, 1'b1);
        end
        tick();
        chk("t4_mreq_reassert", m_req, 1'b1);
        ret_allow = -1;
        wait_cmds("t4_cmd_timeout", 50);
        wait_drain("t4_drain_timeout", 50);

        // 5: read ack coinciding with a second beat keeps tag order
        clear_logs();
        cmd_left[0] = 3; rd[0] = 1;
        wait_cmds("t5_c0_timeout", 50);
        cmd_left[1] = 1; rd[1] = 1;
        wait_cmds("t5_c1_timeout", 50);
        wait_drain("t5_drain_timeout", 50);
        chk("t5_push_pop_seen", coincide > 0, 1'b1);
        chk("t5_nbeats", valid_log.size(), 8);
        for (int i = 0; i < valid_log.size(); i++)
            chk("t5_beat_dest", valid_log[i], (i < 6) ? 0 : 1);

        // 6: orphan beat with nothing outstanding, then reset mid-grant
        force_orphan = 1;
        tick();
        repeat (3) tick();
        chk("t6_orphan_sticky", err_orphan, 1'b1);
        cmd_left[0] = -1; rd[0] = 1;
        begin
            int n = 0;
            while (!(busy && m_req) && n < 20) begin tick(); n++; end
            chk("t6_grant_timeout", n < 20, 1'b1);
        end
        #2;
        RST = 1'b1;
        #1;
        chk("t6_rst_mreq", m_req, 1'b0);
        chk("t6_rst_busy", busy, 1'b0);
        chk("t6_rst_err", err_orphan, 1'b0);
        do_reset();

        // Randomized traffic
        ack_pct = 70; ret_pct = 60;
        for (int c = 0; c < 600; c++) begin
            for (int k = 0; k < 2; k++) begin
                if (cmd_left[k] == 0 && c < 550 && $urandom_range(0, 3) == 0) begin
                    cmd_left[k] = $urandom_range(1, 6);
                    rd[k] = 1'($urandom_range(0, 1));
                end
            end
            tick();
        end
        ack_pct = 100; ret_pct = 100;
        wait_cmds("rand_cmd_timeout", 300);
        wait_drain("rand_drain_timeout", 300);
        chk("rand_beats", vcnt[0] + vcnt[1], 2 * reads_issued);
        chk("rand_idle", busy, 1'b0);
        chk("rand_no_orphan", err_orphan, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
